mc_control: RTL

Multicycle control sequencer for the 32-bit MIPS-subset datapath. Decodes the instruction register's opcode/funct and steps the shared datapath through fetch, decode, execute, memory and write-back, one phase per clock. It drives the immediate extender's mode select, ALU operand muxes, register-file and PC write enables, and a request/ready handshake to the unified instruction/data memory.

---
 rtl/mc_control.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle control sequencer for the 32-bit MIPS-subset datapath.
// Steps the shared datapath one phase per clock: FETCH, DECODE, EXEC_R/EXEC_I or
// ADDR, MEM_RD/MEM_WR, WB_ALU/WB_MEM, BRANCH, JUMP. Outputs are decoded from the
// state register, plus opcode/funct in the execute, address and write-back phases.
//
// Purpose     : decode IR opcode/funct and sequence the datapath controls.
// Latency     : R/I-type 4, lw 5, sw 4, beq 3, j 3, illegal opcode 2 cycles (no waits).
// Backpressure: memory phases hold mem_req with stable iord/mem_we until mem_ready=1.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   opcode, funct        IR[31:26] / IR[5:0], valid from DECODE onward
//   zero                 ALU zero flag, used only in BRANCH
//   mem_ready            memory completes the current access this cycle
//   mem_req, mem_we      memory request and write qualifier
//   iord                 memory address select (0 PC, 1 ALU-out)
//   ir_write, pc_write   IR load / unconditional PC load
//   pc_src               0 ALU result, 1 ALU-out (branch target), 2 jump target
//   reg_write, reg_dst   register-file write enable / destination (0 rt, 1 rd)
//   mem_to_reg           write-back source (0 ALU-out, 1 memory data register)
//   alu_src_a, alu_src_b ALU operand selects
//   alu_op               0 add, 1 sub, 2 and, 3 or, 4 slt
//   ext_mode             immediate extender: 0 sign, 1 zero, 2 upper
//   illegal              one-cycle pulse on unsupported opcode/funct
//
// Build option: define MC_CONTROL_LUI_EN to support lui (opcode 0x0F).
// Without it 0x0F is illegal and ext_mode never takes the value 2.

module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] ext_mode,
  output logic       illegal
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MC_CONTROL_LUI_EN
  localparam logic [5:0] OP_LUI   = 6'h0F;
`endif

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Operand B selects
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // PC sources
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Extender modes
  localparam logic [1:0] EXT_SIGN  = 2'd0;
  localparam logic [1:0] EXT_ZERO  = 2'd1;
`ifdef MC_CONTROL_LUI_EN
  localparam logic [1:0] EXT_UPPER = 2'd2;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d;

  // State register. Reset forces IDLE immediately; because every output is
  // decoded from state_q, all outputs fall to 0 as soon as rst_n goes low,
  // even in the middle of a memory access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Outputs depend on the current state and,
  // where the phase needs it, on opcode/funct, mem_ready (FETCH completion)
  // and zero (BRANCH). Everything defaults to 0.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    ext_mode   = EXT_SIGN;
    illegal    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC + 4 is computed every FETCH cycle; it is only committed (together
      // with the IR load) in the cycle memory returns the instruction.
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_ALU;
          state_d  = S_DECODE;
        end
      end

      // The ALU precomputes PC + (sext(imm) << 2) so BRANCH can load the
      // target from the ALU-out register without another add.
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_mode  = EXT_SIGN;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_LW, OP_SW:     state_d = S_ADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI,
          OP_ORI:           state_d = S_EXEC_I;
`ifdef MC_CONTROL_LUI_EN
          OP_LUI:           state_d = S_EXEC_I;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        state_d   = S_WB_ALU;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_WB_ALU;
        case (opcode)
          OP_ANDI: begin
            ext_mode = EXT_ZERO;
            alu_op   = ALU_AND;
          end
          OP_ORI: begin
            ext_mode = EXT_ZERO;
            alu_op   = ALU_OR;
          end
`ifdef MC_CONTROL_LUI_EN
          // The datapath zeroes register A for lui, so A | (imm << 16)
          // yields the upper-immediate value.
          OP_LUI: begin
            ext_mode = EXT_UPPER;
            alu_op   = ALU_OR;
          end
`endif
          default: begin
            // addi (the only other opcode that reaches EXEC_I)
            ext_mode = EXT_SIGN;
            alu_op   = ALU_ADD;
          end
        endcase
      end

      S_WB_ALU: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        reg_dst    = (opcode == OP_RTYPE);
        state_d    = S_FETCH;
      end

      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_mode  = EXT_SIGN;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        state_d  = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
